// File: rtl/muldiv_ctrl.sv
// Iterative RV32M multiply/divide unit: a single shift-add or restoring
// shift-subtract step per cycle, with an immediate result for divide-by-zero
// and signed overflow, and a valid/ready handshake on request and response.
module muldiv_ctrl #(
  parameter int unsigned DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [2:0]           op_i,
  input  logic [DataWidth-1:0] src1_i,
  input  logic [DataWidth-1:0] src2_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [DataWidth-1:0] result_o,
  output logic                 busy_o
);

  localparam int unsigned CntWidth = $clog2(DataWidth) + 1;
  localparam logic [CntWidth-1:0] LastStep = CntWidth'(DataWidth - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  state_e                 state;
  logic [CntWidth-1:0]    cnt;
  logic [2:0]             op_q;
  logic [DataWidth-1:0]   b_q;
  logic [2*DataWidth-1:0] acc_q;
  logic                   neg_q;
  logic                   neg_r;

  logic                   is_div;
  logic                   sign1;
  logic                   sign2;
  logic [DataWidth-1:0]   mag1;
  logic [DataWidth-1:0]   mag2;
  logic                   div_zero;
  logic                   div_ovf;
  logic                   bypass;
  logic [DataWidth-1:0]   bypass_res;

  logic [DataWidth:0]     mul_sum;
  logic [DataWidth:0]     div_shift;
  logic [DataWidth:0]     div_diff;
  logic [2*DataWidth-1:0] acc_next;
  logic [2*DataWidth-1:0] prod;
  logic [DataWidth-1:0]   quo;
  logic [DataWidth-1:0]   rem;
  logic [DataWidth-1:0]   final_res;

  assign req_ready_o = (state == IDLE);
  assign busy_o      = (state != IDLE);

  // Request decode: operand signs, magnitudes and the short-circuit cases.
  always_comb begin
    is_div   = op_i[2];
    sign1    = src1_i[DataWidth-1] &&
               ((op_i == OP_MULH) || (op_i == OP_MULHSU) ||
                (op_i == OP_DIV)  || (op_i == OP_REM));
    sign2    = src2_i[DataWidth-1] &&
               ((op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM));
    mag1     = sign1 ? (~src1_i + 1'b1) : src1_i;
    mag2     = sign2 ? (~src2_i + 1'b1) : src2_i;
    div_zero = is_div && (src2_i == '0);
    div_ovf  = ((op_i == OP_DIV) || (op_i == OP_REM)) &&
               (src1_i == {1'b1, {(DataWidth-1){1'b0}}}) && (src2_i == '1);
    bypass   = div_zero || div_ovf;
    if (op_i[1]) begin
      bypass_res = div_zero ? src1_i : '0;
    end else begin
      bypass_res = div_zero ? '1 : src1_i;
    end
  end

  // One iteration step and the sign-corrected result of the final step.
  // Multiply keeps {partial product, multiplier} in acc_q; divide keeps
  // {partial remainder, dividend/quotient} and shifts quotient bits in at the bottom.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*DataWidth-1:DataWidth]} +
                (acc_q[0] ? {1'b0, b_q} : '0);
    div_shift = acc_q[2*DataWidth-1:DataWidth-1];
    div_diff  = div_shift - {1'b0, b_q};
    if (!op_q[2]) begin
      acc_next = {mul_sum, acc_q[DataWidth-1:1]};
    end else if (!div_diff[DataWidth]) begin
      acc_next = {div_diff[DataWidth-1:0], acc_q[DataWidth-2:0], 1'b1};
    end else begin
      acc_next = {div_shift[DataWidth-1:0], acc_q[DataWidth-2:0], 1'b0};
    end
    prod = neg_q ? (~acc_next + 1'b1) : acc_next;
    quo  = acc_next[DataWidth-1:0];
    rem  = acc_next[2*DataWidth-1:DataWidth];
    if (!op_q[2]) begin
      final_res = (op_q == OP_MUL) ? prod[DataWidth-1:0]
                                   : prod[2*DataWidth-1:DataWidth];
    end else if (op_q[1]) begin
      final_res = neg_r ? (~rem + 1'b1) : rem;
    end else begin
      final_res = neg_q ? (~quo + 1'b1) : quo;
    end
  end

  // Control FSM and datapath registers; reset, then flush, take priority.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state       <= IDLE;
      cnt         <= '0;
      rsp_valid_o <= 1'b0;
      result_o    <= '0;
      op_q        <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
    end else if (flush_i) begin
      state       <= IDLE;
      cnt         <= '0;
      rsp_valid_o <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid_i) begin
            op_q  <= op_i;
            neg_q <= sign1 ^ sign2;
            neg_r <= sign1;
            cnt   <= '0;
            if (bypass) begin
              result_o    <= bypass_res;
              rsp_valid_o <= 1'b1;
              state       <= DONE;
            end else begin
              acc_q <= {{DataWidth{1'b0}}, (is_div ? mag1 : mag2)};
              b_q   <= is_div ? mag2 : mag1;
              state <= CALC;
            end
          end
        end
        CALC: begin
          acc_q <= acc_next;
          cnt   <= cnt + CntWidth'(1);
          if (cnt == LastStep) begin
            result_o    <= final_res;
            rsp_valid_o <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
